// File: rtl/geofence_seq_ctrl_if.sv
// Strobe/handshake bundle between the geofence sequencer (master) and its datapath (slave).
// timeout_err is present only when GEOFENCE_TIMEOUT_EN is defined.
interface geofence_seq_ctrl_if;
    logic       load_en;
    logic [2:0] num;
    logic       sort_req;
    logic [2:0] sort_a;
    logic [2:0] sort_b;
    logic       sort_gt;
    logic       swap;
    logic       acc_clr;
    logic       hex_step;
    logic       tri_start;
    logic       tri_done;
    logic       area_cmp_in;
    logic       valid;
    logic       is_inside;
    logic       busy;
`ifdef GEOFENCE_TIMEOUT_EN
    logic       timeout_err;
`endif

    modport master (
        output load_en, num, sort_req, sort_a, sort_b, swap, acc_clr, hex_step,
               tri_start, valid, is_inside, busy,
`ifdef GEOFENCE_TIMEOUT_EN
        output timeout_err,
`endif
        input  sort_gt, tri_done, area_cmp_in
    );

    modport slave (
        input  load_en, num, sort_req, sort_a, sort_b, swap, acc_clr, hex_step,
               tri_start, valid, is_inside, busy,
`ifdef GEOFENCE_TIMEOUT_EN
        input  timeout_err,
`endif
        output sort_gt, tri_done, area_cmp_in
    );
endinterface

// File: rtl/geofence_seq_ctrl.sv
// Geofence master sequencer: load -> bubble sort -> hex area -> Heron triangles -> verdict.
// Define GEOFENCE_TIMEOUT_EN to bound the tri_done wait and add timeout_err.
module geofence_seq_ctrl #(
    parameter int unsigned NPTS    = 6,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    geofence_seq_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_LOAD, S_SORT, S_CLR, S_HEX, S_TRI, S_WAIT, S_DECIDE, S_OUT
    } state_t;

    localparam logic [2:0] LAST = 3'(NPTS - 1);
    localparam logic [2:0] LIM0 = 3'(NPTS - 2);

    if (NPTS < 3 || NPTS > 7 || TIMEOUT < 2) begin : g_bad_cfg
        $error("geofence_seq_ctrl: NPTS must be 3..7 and TIMEOUT >= 2");
    end

    state_t     r_state, w_state_nx;
    logic [2:0] r_num, w_num_nx;
    logic [2:0] r_j, w_j_nx;
    logic [2:0] r_lim, w_lim_nx;
    logic       r_c2, w_c2_nx;
    logic       r_inside, w_inside_nx;

    logic w_load_en, w_sort_req, w_swap, w_acc_clr, w_hex_step;
    logic w_tri_start, w_valid, w_is_inside;

`ifdef GEOFENCE_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    logic [CW-1:0] r_wait, w_wait_nx;
    logic          r_tmo, w_tmo_nx;
    logic          w_timeout_err;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_LOAD;
            r_num    <= '0;
            r_j      <= 3'd1;
            r_lim    <= LIM0;
            r_c2     <= 1'b0;
            r_inside <= 1'b0;
`ifdef GEOFENCE_TIMEOUT_EN
            r_wait   <= '0;
            r_tmo    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nx;
            r_num    <= w_num_nx;
            r_j      <= w_j_nx;
            r_lim    <= w_lim_nx;
            r_c2     <= w_c2_nx;
            r_inside <= w_inside_nx;
`ifdef GEOFENCE_TIMEOUT_EN
            r_wait   <= w_wait_nx;
            r_tmo    <= w_tmo_nx;
`endif
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_num_nx    = r_num;
        w_j_nx      = r_j;
        w_lim_nx    = r_lim;
        w_c2_nx     = r_c2;
        w_inside_nx = r_inside;
        w_load_en   = 1'b0;
        w_sort_req  = 1'b0;
        w_swap      = 1'b0;
        w_acc_clr   = 1'b0;
        w_hex_step  = 1'b0;
        w_tri_start = 1'b0;
        w_valid     = 1'b0;
        w_is_inside = 1'b0;
`ifdef GEOFENCE_TIMEOUT_EN
        w_wait_nx     = r_wait;
        w_tmo_nx      = r_tmo;
        w_timeout_err = 1'b0;
`endif
        case (r_state)
            S_LOAD: begin
                w_load_en = 1'b1;
                if (r_num == LAST) begin
                    w_num_nx   = '0;
                    w_j_nx     = 3'd1;
                    w_lim_nx   = LIM0;
                    w_c2_nx    = 1'b0;
                    w_state_nx = S_SORT;
                end else begin
                    w_num_nx = r_num + 3'd1;
                end
            end
            S_SORT: begin
                // r_lim is the last compare index of the current pass; it shrinks by one per pass
                if (!r_c2) begin
                    w_sort_req = 1'b1;
                    w_c2_nx    = 1'b1;
                end else begin
                    w_swap  = bus.sort_gt;
                    w_c2_nx = 1'b0;
                    if (r_j == r_lim) begin
                        w_j_nx = 3'd1;
                        if (r_lim == 3'd1) w_state_nx = S_CLR;
                        else               w_lim_nx   = r_lim - 3'd1;
                    end else begin
                        w_j_nx = r_j + 3'd1;
                    end
                end
            end
            S_CLR: begin
                w_acc_clr  = 1'b1;
                w_num_nx   = '0;
                w_state_nx = S_HEX;
            end
            S_HEX: begin
                w_hex_step = 1'b1;
                if (r_num == LAST) begin
                    w_num_nx   = '0;
                    w_state_nx = S_TRI;
                end else begin
                    w_num_nx = r_num + 3'd1;
                end
            end
            S_TRI: begin
                w_tri_start = 1'b1;
                w_state_nx  = S_WAIT;
`ifdef GEOFENCE_TIMEOUT_EN
                w_wait_nx   = CW'(1);
`endif
            end
            S_WAIT: begin
                if (bus.tri_done) begin
                    if (r_num == LAST) begin
                        w_state_nx = S_DECIDE;
                    end else begin
                        w_num_nx   = r_num + 3'd1;
                        w_state_nx = S_TRI;
                    end
                end
`ifdef GEOFENCE_TIMEOUT_EN
                else if (r_wait == CW'(TIMEOUT - 1)) begin
                    w_state_nx  = S_OUT;
                    w_inside_nx = 1'b0;
                    w_tmo_nx    = 1'b1;
                end else begin
                    w_wait_nx = r_wait + 1'b1;
                end
`endif
            end
            S_DECIDE: begin
                w_inside_nx = ~bus.area_cmp_in;
                w_state_nx  = S_OUT;
            end
            S_OUT: begin
                w_valid     = 1'b1;
                w_is_inside = r_inside;
                w_inside_nx = 1'b0;
                w_num_nx    = '0;
                w_state_nx  = S_LOAD;
`ifdef GEOFENCE_TIMEOUT_EN
                w_timeout_err = r_tmo;
                w_tmo_nx      = 1'b0;
`endif
            end
            default: w_state_nx = S_LOAD;
        endcase
    end

    // Outputs are held quiet while reset is asserted so an aborted set emits no strobes.
    assign bus.load_en   = w_load_en & ~reset;
    assign bus.num       = reset ? '0 : r_num;
    assign bus.sort_req  = w_sort_req & ~reset;
    assign bus.sort_a    = (reset || r_state != S_SORT) ? '0 : r_j;
    assign bus.sort_b    = (reset || r_state != S_SORT) ? '0 : r_j + 3'd1;
    assign bus.swap      = w_swap & ~reset;
    assign bus.acc_clr   = w_acc_clr & ~reset;
    assign bus.hex_step  = w_hex_step & ~reset;
    assign bus.tri_start = w_tri_start & ~reset;
    assign bus.valid     = w_valid & ~reset;
    assign bus.is_inside = w_is_inside & ~reset;
    assign bus.busy      = (r_state != S_LOAD) & ~reset;
`ifdef GEOFENCE_TIMEOUT_EN
    assign bus.timeout_err = w_timeout_err & ~reset;
`endif
endmodule

// File: tb/tb_geofence_seq_ctrl.sv
// Randomized bench for geofence_seq_ctrl: a per-set expected output trace is built from the
// phase rules (loops over slots, passes, edges) and compared cycle by cycle.
module tb_geofence_seq_ctrl;
    localparam int unsigned NPTS    = 6;
    localparam int unsigned TIMEOUT = 255;
    localparam int unsigned HANG    = 300;

    localparam logic [18:0] M_BASE = 19'b1_000_1_000_000_11111111;
    localparam logic [18:0] M_NUM  = 19'b0_111_0_000_000_00000000;
    localparam logic [18:0] M_AB   = 19'b0_000_0_111_111_00000000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    geofence_seq_ctrl_if bus();

    geofence_seq_ctrl #(.NPTS(NPTS), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [18:0] v;
        logic [18:0] m;
        logic        gt;
        logic        done;
        logic        area;
    } step_t;

    step_t       trace[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {load_en,num,sort_req,sort_a,sort_b,swap,acc_clr,hex_step,tri_start,valid,is_inside,busy,timeout_err}
    function automatic logic [18:0] obs_vec();
        logic t;
        t = 1'b0;
`ifdef GEOFENCE_TIMEOUT_EN
        t = bus.timeout_err;
`endif
        return {bus.load_en, bus.num, bus.sort_req, bus.sort_a, bus.sort_b, bus.swap,
                bus.acc_clr, bus.hex_step, bus.tri_start, bus.valid, bus.is_inside, bus.busy, t};
    endfunction

    function automatic logic [18:0] pk(input logic ld, input logic [2:0] n, input logic rq,
                                       input logic [2:0] a, input logic [2:0] b, input logic sw,
                                       input logic clr, input logic hx, input logic ts,
                                       input logic vl, input logic ins, input logic bsy,
                                       input logic tmo);
        return {ld, n, rq, a, b, sw, clr, hx, ts, vl, ins, bsy, tmo};
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic void push(input logic [18:0] v, input bit num_c, input bit ab_c,
                                 input logic gt, input logic done, input logic area);
        step_t s;
        s.v    = v;
        s.m    = M_BASE | (num_c ? M_NUM : '0) | (ab_c ? M_AB : '0);
        s.gt   = gt;
        s.done = done;
        s.area = area;
        trace.push_back(s);
    endfunction

    // gt_mode 0/1: constant sort_gt, 2: random per compare. hang: tri_done never comes on edge 0.
    task automatic build_set(input int gt_mode, input int unsigned lat [NPTS],
                             input logic area, input bit hang);
        logic g;
        trace.delete();
        for (int unsigned i = 0; i < NPTS; i++)
            push(pk(1, 3'(i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0, rb(), rb(), rb());
        for (int unsigned p = 0; p + 3 <= NPTS; p++) begin
            for (int unsigned j = 1; j + p + 2 <= NPTS; j++) begin
                g = (gt_mode == 2) ? rb() : 1'(gt_mode);
                push(pk(0, 0, 1, 3'(j), 3'(j + 1), 0, 0, 0, 0, 0, 0, 1, 0), 0, 1, rb(), rb(), rb());
                push(pk(0, 0, 0, 3'(j), 3'(j + 1), g, 0, 0, 0, 0, 0, 1, 0), 0, 1, g, rb(), rb());
            end
        end
        push(pk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0), 0, 0, rb(), rb(), rb());
        for (int unsigned i = 0; i < NPTS; i++)
            push(pk(0, 3'(i), 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0), 1, 0, rb(), rb(), rb());
        for (int unsigned e = 0; e < NPTS; e++) begin
            push(pk(0, 3'(e), 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0), 1, 0, rb(), rb(), rb());
            if (hang) begin
`ifdef GEOFENCE_TIMEOUT_EN
                for (int unsigned k = 1; k < TIMEOUT; k++)
                    push(pk(0, 3'(e), 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1, 0, rb(), 0, rb());
                push(pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1), 0, 0, rb(), rb(), rb());
`else
                for (int unsigned k = 0; k < HANG; k++)
                    push(pk(0, 3'(e), 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1, 0, rb(), 0, rb());
`endif
                return;
            end
            for (int unsigned k = 1; k <= lat[e]; k++)
                push(pk(0, 3'(e), 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1, 0, rb(), 1'(k == lat[e]), rb());
        end
        push(pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 0, 0, rb(), rb(), area);
        push(pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ~area, 1, 0), 0, 0, rb(), rb(), rb());
    endtask

    // Entered and left at posedge+1; abort_at >= 0 stops before that cycle index.
    task automatic run_trace(input string name, input int abort_at, output int valid_cyc);
        logic [18:0] o;
        valid_cyc = -1;
        foreach (trace[k]) begin
            if (abort_at >= 0 && k == abort_at) break;
            bus.sort_gt     = trace[k].gt;
            bus.tri_done    = trace[k].done;
            bus.area_cmp_in = trace[k].area;
            @(negedge clk);
            o = obs_vec();
            chk($sformatf("%s_c%0d", name, k), 32'(o & trace[k].m), 32'(trace[k].v & trace[k].m));
            if (o[3]) valid_cyc = k;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        bus.sort_gt     = 1'b0;
        bus.tri_done    = 1'b0;
        bus.area_cmp_in = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_quiet", 32'(obs_vec()), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int unsigned lat [NPTS];
        int          vc;
        bus.sort_gt     = 1'b0;
        bus.tri_done    = 1'b0;
        bus.area_cmp_in = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        for (int unsigned e = 0; e < NPTS; e++) lat[e] = 3;
        build_set(0, lat, 1'b0, 1'b0);
        run_trace("gt0", -1, vc);
        chk("valid_cyc_gt0", 32'(vc), 32'd58);

        build_set(1, lat, 1'b0, 1'b0);
        run_trace("gt1", -1, vc);
        chk("valid_cyc_gt1", 32'(vc), 32'd58);

        build_set(2, lat, 1'b1, 1'b0);
        run_trace("outside", -1, vc);
        chk("valid_cyc_out", 32'(vc), 32'd58);

        build_set(2, lat, 1'b1, 1'b0);
        run_trace("abort", 40, vc);
        do_reset();
        chk("abort_no_valid", 32'(vc), 32'hffff_ffff);

        for (int unsigned s = 0; s < 6; s++) begin
            for (int unsigned e = 0; e < NPTS; e++) lat[e] = $urandom_range(6, 1);
            build_set(2, lat, rb(), 1'b0);
            run_trace($sformatf("rnd%0d", s), -1, vc);
        end

        build_set(2, lat, 1'b0, 1'b1);
        run_trace("hang", -1, vc);
`ifdef GEOFENCE_TIMEOUT_EN
        chk("tmo_valid_cyc", 32'(vc), 32'(33 + TIMEOUT));
`else
        chk("hang_no_valid", 32'(vc), 32'hffff_ffff);
`endif
        do_reset();

        for (int unsigned e = 0; e < NPTS; e++) lat[e] = $urandom_range(4, 1);
        build_set(2, lat, rb(), 1'b0);
        run_trace("post", -1, vc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
